// File: rtl/nv_nvdla_sdp_hls_y_out_cvt.sv
// SDP Y-path output converter.
// Each lane computes offset-subtract, scale, round-shift and int16 saturation
// in a three-stage valid/ready pipeline. All lanes share one handshake.
// Optional saturation event counter: define NVDLA_SDP_Y_OUT_CVT_SAT_CNT_EN.

// One lane of the converter. Stage enables come from the shared pipeline control.
module nv_nvdla_sdp_hls_y_out_cvt_lane (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ld1,
    input  logic        ld2,
    input  logic        ld3,
    input  logic        bypass,
    input  logic [31:0] offset,
    input  logic [15:0] scale,
    input  logic [5:0]  truncate,
    input  logic [31:0] din,
    output logic [15:0] dout,
    output logic        sat
);
    logic signed [32:0] d1_q, d1_d;
    logic signed [48:0] p_q, p_d;
    logic        [15:0] dout_q, dout_d;
    logic               sat_q, sat_d;

    logic signed [48:0] d1_x, sc_x;
    // Wide enough that the rounding add cannot overflow for any shift 0..63.
    logic signed [65:0] p_x, rnd, r;

    // S1: subtract offset (33-bit, exact), or carry the low 16 bits in bypass.
    always_comb begin
        d1_d = d1_q;
        if (ld1) begin
            if (bypass) d1_d = {17'b0, din[15:0]};
            else        d1_d = $signed({din[31], din}) - $signed({offset[31], offset});
        end
    end

    // S2: signed multiply by scale; bypass keeps the raw 16 bits.
    always_comb begin
        d1_x = {{16{d1_q[32]}}, d1_q};
        sc_x = {{33{scale[15]}}, scale};
        p_d  = p_q;
        if (ld2) begin
            if (bypass) p_d = {33'b0, d1_q[15:0]};
            else        p_d = d1_x * sc_x;
        end
    end

    // S3: round-half-up arithmetic shift, then clamp to int16.
    always_comb begin
        p_x = {{17{p_q[48]}}, p_q};
        rnd = '0;
        if (truncate != 6'd0) rnd = 66'sd1 <<< (truncate - 6'd1);
        r      = (p_x + rnd) >>> truncate;
        dout_d = dout_q;
        sat_d  = sat_q;
        if (ld3) begin
            if (bypass) begin
                dout_d = p_q[15:0];
                sat_d  = 1'b0;
            end else if (r > 66'sd32767) begin
                dout_d = 16'h7fff;
                sat_d  = 1'b1;
            end else if (r < -66'sd32768) begin
                dout_d = 16'h8000;
                sat_d  = 1'b1;
            end else begin
                dout_d = r[15:0];
                sat_d  = 1'b0;
            end
        end
    end

    // Lane data registers for all three stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1_q   <= '0;
            p_q    <= '0;
            dout_q <= '0;
            sat_q  <= 1'b0;
        end else begin
            d1_q   <= d1_d;
            p_q    <= p_d;
            dout_q <= dout_d;
            sat_q  <= sat_d;
        end
    end

    assign dout = dout_q;
    assign sat  = sat_q;
endmodule

module nv_nvdla_sdp_hls_y_out_cvt #(
    parameter int THROUGHPUT = 4
) (
    input  logic                     nvdla_core_clk,
    input  logic                     nvdla_core_rstn,
    input  logic                     cfg_cvt_bypass,
    input  logic [31:0]              cfg_cvt_offset,
    input  logic [15:0]              cfg_cvt_scale,
    input  logic [5:0]               cfg_cvt_truncate,
    input  logic                     cfg_sat_cnt_clr,
    input  logic                     cvt_in_pvld,
    output logic                     cvt_in_prdy,
    input  logic [THROUGHPUT*32-1:0] cvt_data_in,
    output logic                     cvt_out_pvld,
    input  logic                     cvt_out_prdy,
    output logic [THROUGHPUT*16-1:0] cvt_data_out,
    output logic [THROUGHPUT-1:0]    cvt_sat_out,
    output logic [31:0]              cvt_sat_cnt
);
    logic [3:1] vld_q, vld_d;
    logic       rdy1, rdy2, rdy3;
    logic       ld1, ld2, ld3;

    // Per-stage ready chain: a stage can take data if empty or draining downstream.
    always_comb begin
        rdy3     = !vld_q[3] | cvt_out_prdy;
        rdy2     = !vld_q[2] | rdy3;
        rdy1     = !vld_q[1] | rdy2;
        ld1      = cvt_in_pvld & rdy1;
        ld2      = vld_q[1] & rdy2;
        ld3      = vld_q[2] & rdy3;
        vld_d[1] = rdy1 ? cvt_in_pvld : vld_q[1];
        vld_d[2] = rdy2 ? vld_q[1]    : vld_q[2];
        vld_d[3] = rdy3 ? vld_q[2]    : vld_q[3];
    end

    // Stage valid bits; reset drops every in-flight beat.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) vld_q <= '0;
        else                  vld_q <= vld_d;
    end

    assign cvt_in_prdy  = rdy1;
    assign cvt_out_pvld = vld_q[3];

    for (genvar i = 0; i < THROUGHPUT; i++) begin : g_lane
        nv_nvdla_sdp_hls_y_out_cvt_lane u_lane (
            .clk      (nvdla_core_clk),
            .rst_n    (nvdla_core_rstn),
            .ld1      (ld1),
            .ld2      (ld2),
            .ld3      (ld3),
            .bypass   (cfg_cvt_bypass),
            .offset   (cfg_cvt_offset),
            .scale    (cfg_cvt_scale),
            .truncate (cfg_cvt_truncate),
            .din      (cvt_data_in[i*32 +: 32]),
            .dout     (cvt_data_out[i*16 +: 16]),
            .sat      (cvt_sat_out[i])
        );
    end

`ifdef NVDLA_SDP_Y_OUT_CVT_SAT_CNT_EN
    logic [31:0] sat_cnt_q, sat_cnt_d;
    logic [31:0] pc;
    logic [32:0] sum;
    logic        hs;

    // Count saturated lanes of each completed beat; clear wins over the old value
    // but still takes the current beat; sticks at all-ones instead of wrapping.
    always_comb begin
        hs = cvt_out_pvld & cvt_out_prdy;
        pc = '0;
        for (int i = 0; i < THROUGHPUT; i++) pc = pc + {31'b0, cvt_sat_out[i]};
        sum       = {1'b0, sat_cnt_q} + {1'b0, pc};
        sat_cnt_d = sat_cnt_q;
        if (cfg_sat_cnt_clr) sat_cnt_d = hs ? pc : '0;
        else if (hs)         sat_cnt_d = sum[32] ? '1 : sum[31:0];
    end

    // Saturation counter register.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) sat_cnt_q <= '0;
        else                  sat_cnt_q <= sat_cnt_d;
    end

    assign cvt_sat_cnt = sat_cnt_q;
`else
    logic unused_sat_cnt_clr;
    assign unused_sat_cnt_clr = cfg_sat_cnt_clr;
    assign cvt_sat_cnt        = '0;
`endif
endmodule

// File: tb/tb_nv_nvdla_sdp_hls_y_out_cvt.sv
// Scoreboard bench for nv_nvdla_sdp_hls_y_out_cvt: expected beats are queued
// at input acceptance from an arithmetic reference model, and a monitor pops
// and compares on every output handshake.
module tb_nv_nvdla_sdp_hls_y_out_cvt;
    localparam int TP = 4;
`ifdef NVDLA_SDP_Y_OUT_CVT_SAT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rstn;
    logic              cfg_bypass;
    logic [31:0]       cfg_off;
    logic [15:0]       cfg_scale;
    logic [5:0]        cfg_trunc;
    logic              cfg_clr;
    logic              in_pvld, in_prdy, out_pvld, out_prdy;
    logic [TP*32-1:0]  data_in;
    logic [TP*16-1:0]  data_out;
    logic [TP-1:0]     sat_out;
    logic [31:0]       sat_cnt;

    nv_nvdla_sdp_hls_y_out_cvt #(.THROUGHPUT(TP)) dut (
        .nvdla_core_clk   (clk),
        .nvdla_core_rstn  (rstn),
        .cfg_cvt_bypass   (cfg_bypass),
        .cfg_cvt_offset   (cfg_off),
        .cfg_cvt_scale    (cfg_scale),
        .cfg_cvt_truncate (cfg_trunc),
        .cfg_sat_cnt_clr  (cfg_clr),
        .cvt_in_pvld      (in_pvld),
        .cvt_in_prdy      (in_prdy),
        .cvt_data_in      (data_in),
        .cvt_out_pvld     (out_pvld),
        .cvt_out_prdy     (out_prdy),
        .cvt_data_out     (data_out),
        .cvt_sat_out      (sat_out),
        .cvt_sat_cnt      (sat_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TP*16-1:0] d;
        logic [TP-1:0]    s;
        int               cyc;
        bit               strict;
    } exp_t;

    exp_t             q[$];
    int               checks = 0;
    int               errors = 0;
    int               cycle  = 0;
    int               pops   = 0;
    bit               strict_lat = 1'b0;
    logic [TP*16-1:0] last_out = '0;
    logic [TP-1:0]    last_sat = '0;
    longint           cnt_m = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Reference: exact integer arithmetic of the conversion rules.
    function automatic void model_lane(input logic [31:0] x, output logic [15:0] o, output logic s);
        longint d, p, r;
        if (cfg_bypass) begin
            o = x[15:0];
            s = 1'b0;
            return;
        end
        d = longint'($signed(x)) - longint'($signed(cfg_off));
        p = d * longint'($signed(cfg_scale));
        if (cfg_trunc == 6'd0) r = p;
        else r = (p + (longint'(1) <<< (cfg_trunc - 1))) >>> cfg_trunc;
        if (r > 32767) begin
            o = 16'h7fff; s = 1'b1;
        end else if (r < -32768) begin
            o = 16'h8000; s = 1'b1;
        end else begin
            o = r[15:0]; s = 1'b0;
        end
    endfunction

    initial forever begin
        @(posedge clk);
        cycle++;
    end

    // Monitor / scoreboard, sampling on the falling edge.
    initial forever begin
        @(negedge clk);
        if (!rstn) begin
            cnt_m = 0;
        end else begin
            exp_t e;
            bit   hs;
            int   pc;
            chk("sat_cnt", {32'b0, sat_cnt}, cnt_m);
            if (in_pvld && in_prdy) begin
                for (int i = 0; i < TP; i++) begin
                    logic [15:0] o;
                    logic        s;
                    model_lane(data_in[i*32 +: 32], o, s);
                    e.d[i*16 +: 16] = o;
                    e.s[i] = s;
                end
                e.cyc    = cycle;
                e.strict = strict_lat;
                q.push_back(e);
            end
            hs = out_pvld && out_prdy;
            pc = 0;
            if (hs) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", {32'b0, data_out}, 64'hdead);
                end else begin
                    e = q.pop_front();
                    pops++;
                    chk("out_data", {32'b0, data_out}, {32'b0, e.d});
                    chk("out_sat", {60'b0, sat_out}, {60'b0, e.s});
                    if (e.strict) chk("latency", 64'(cycle - e.cyc), 64'd3);
                    for (int i = 0; i < TP; i++) pc += int'(e.s[i]);
                end
                last_out = data_out;
                last_sat = sat_out;
            end
            if (CNT_EN) begin
                if (cfg_clr)  cnt_m = hs ? pc : 0;
                else if (hs)  cnt_m = (cnt_m + pc > 64'hffffffff) ? 64'hffffffff : cnt_m + pc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [TP*32-1:0] d);
        bit acc = 1'b0;
        data_in = d;
        in_pvld = 1'b1;
        for (int n = 0; n < 100 && !acc; n++) begin
            @(negedge clk);
            acc = in_prdy;
            @(posedge clk);
            #1;
        end
        in_pvld = 1'b0;
        chk("send_accept", {63'b0, acc}, 64'd1);
    endtask

    task automatic drain();
        bit done = 1'b0;
        in_pvld  = 1'b0;
        out_prdy = 1'b1;
        for (int n = 0; n < 100 && !done; n++) begin
            tick();
            done = (q.size() == 0) && !out_pvld;
        end
        chk("drain", {63'b0, done}, 64'd1);
    endtask

    task automatic set_cfg(input logic byp, input logic [31:0] off, input logic [15:0] sc, input logic [5:0] t);
        cfg_bypass = byp;
        cfg_off    = off;
        cfg_scale  = sc;
        cfg_trunc  = t;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int stale;
        int pops0;
        logic [TP*32-1:0] d;
        rstn = 1'b0; in_pvld = 1'b0; out_prdy = 1'b1; data_in = '0; cfg_clr = 1'b0;
        set_cfg(1'b0, 32'd0, 16'd1, 6'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_pvld", {63'b0, out_pvld}, 64'd0);
        chk("rst_data_out", {32'b0, data_out}, 64'd0);
        chk("rst_sat_out", {60'b0, sat_out}, 64'd0);
        chk("rst_sat_cnt", {32'b0, sat_cnt}, 64'd0);
        chk("rst_in_prdy", {63'b0, in_prdy}, 64'd1);
        rstn = 1'b1;
        tick();

        // Passthrough: lane0..3 = 100, -5, 0, 32767.
        strict_lat = 1'b1;
        send({32'd32767, 32'd0, -32'sd5, 32'd100});
        drain();
        chk("pass_out", {32'b0, last_out}, 64'h7fff_0000_fffb_0064);
        chk("pass_sat", {60'b0, last_sat}, 64'd0);

        // Rounding: offset 10, scale 3, shift 2.
        set_cfg(1'b0, 32'd10, 16'd3, 6'd2);
        send({32'd0, 32'd0, 32'd5, 32'd15});
        drain();
        chk("round_pos", {48'b0, last_out[15:0]}, 64'h0004);
        chk("round_neg", {48'b0, last_out[31:16]}, 64'hfffc);

        // Saturation: lane0..3 = 2, -2, 1, 0 with scale 0x7FFF. Lane 2 lands
        // exactly on 32767 and is in range, so two lanes saturate per beat.
        set_cfg(1'b0, 32'd0, 16'h7fff, 6'd0);
        d = {32'd0, 32'd1, -32'sd2, 32'd2};
        send(d);
        drain();
        chk("sat_out_data", {32'b0, last_out}, 64'h0000_7fff_8000_7fff);
        chk("sat_flags", {60'b0, last_sat}, 64'b0011);
        chk("sat_cnt_1", {32'b0, sat_cnt}, CNT_EN ? 64'd2 : 64'd0);
        send(d);
        drain();
        chk("sat_cnt_2", {32'b0, sat_cnt}, CNT_EN ? 64'd4 : 64'd0);
        send(d);
        tick();
        tick();
        cfg_clr = 1'b1;
        tick();
        cfg_clr = 1'b0;
        drain();
        chk("sat_cnt_clr", {32'b0, sat_cnt}, CNT_EN ? 64'd2 : 64'd0);

        // Bypass keeps the low 16 bits untouched.
        set_cfg(1'b1, 32'd7, 16'd9, 6'd4);
        send({32'h7777_0123, 32'hffff_ffff, 32'h1234_5678, 32'h0001_8000});
        drain();
        chk("byp_lane0", {48'b0, last_out[15:0]}, 64'h8000);
        chk("byp_sat", {60'b0, last_sat}, 64'd0);

        // Backpressure: 8 beats with the output stalled for 5 cycles.
        set_cfg(1'b0, 32'd0, 16'd1, 6'd0);
        strict_lat = 1'b0;
        pops0 = pops;
        out_prdy = 1'b0;
        fork
            begin
                repeat (5) @(posedge clk);
                #1;
                out_prdy = 1'b1;
            end
        join_none
        for (int k = 1; k <= 8; k++) begin
            send({4{32'(k)}});
            if (k == 3) begin
                @(negedge clk);
                chk("bp_in_prdy", {63'b0, in_prdy}, 64'd0);
                chk("bp_out_pvld", {63'b0, out_pvld}, 64'd1);
                @(posedge clk);
                #1;
            end
        end
        drain();
        chk("bp_count", 64'(pops - pops0), 64'd8);

        // Reset with beats in flight.
        out_prdy = 1'b0;
        send({4{32'd11}});
        send({4{32'd22}});
        tick();
        #2;
        rstn = 1'b0;
        #1;
        chk("rst_fly_pvld", {63'b0, out_pvld}, 64'd0);
        chk("rst_fly_cnt", {32'b0, sat_cnt}, 64'd0);
        chk("rst_fly_data", {32'b0, data_out}, 64'd0);
        q.delete();
        out_prdy = 1'b1;
        tick();
        rstn = 1'b1;
        stale = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (out_pvld) stale++;
        end
        chk("rst_no_stale", 64'(stale), 64'd0);
        tick();

        // Randomised traffic across several configurations.
        for (int blk = 0; blk < 8; blk++) begin
            set_cfg(($urandom % 6) == 0,
                    ($urandom % 2) ? 32'($urandom) : 32'($urandom_range(0, 400)) - 32'd200,
                    ($urandom % 2) ? 16'($urandom) : 16'($urandom_range(0, 64)) - 16'd32,
                    ($urandom % 2) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 20)));
            repeat (80) begin
                in_pvld = ($urandom % 4) != 0;
                for (int i = 0; i < TP; i++)
                    data_in[i*32 +: 32] = ($urandom % 3 == 0) ? 32'($urandom)
                                                               : 32'($urandom_range(0, 2000)) - 32'd1000;
                out_prdy = ($urandom % 3) != 0;
                cfg_clr  = ($urandom % 25) == 0;
                tick();
            end
            cfg_clr = 1'b0;
            drain();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
